// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if: control/status bundle between a BIST requester and ram_bist_ctrl.
// With RAM_BIST_ERR_INJECT_EN defined the bundle also carries err_inject.
//
// Handshake: start is a level that the controller samples on every rising edge.
// It is taken only while busy=0 (IDLE); there is no ready signal and start
// is ignored at all other times. Once a test is taken, busy stays high until
// the cycle after the single-cycle done pulse. rd_valid marks each cycle on
// which rd_data holds a read-pass word that is being compared.
interface ram_bist_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
`ifdef RAM_BIST_ERR_INJECT_EN
    logic              err_inject;

    modport master (output start, mode, err_inject,
                    input  busy, done, pass, err_cnt, first_err_addr, rd_data, rd_valid);
    modport slave  (input  start, mode, err_inject,
                    output busy, done, pass, err_cnt, first_err_addr, rd_data, rd_valid);
`else
    modport master (output start, mode,
                    input  busy, done, pass, err_cnt, first_err_addr, rd_data, rd_valid);
    modport slave  (input  start, mode,
                    output busy, done, pass, err_cnt, first_err_addr, rd_data, rd_valid);
`endif
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: writes a pattern to an internal simple dual-port RAM,
// waits GAP_CYC idle cycles, reads every word back and counts mismatches.
// Optional feature macro: RAM_BIST_ERR_INJECT_EN (adds err_inject; when latched
// high, bit 0 of the word written to address 3 is inverted).
module ram_bist_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int GAP_CYC = 476,
    parameter int RD_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_bist_ctrl_if.slave bus,
    output logic [2:0]     dbg_state_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int CNT_W = (GAP_W > ADDR_W) ? GAP_W : ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              pass_q, pass_d;
    logic              inj_q, inj_d;

    logic              wren, rden;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd1_q, rd2_q, exp1_q, exp2_q;
    logic [ADDR_W-1:0] adr1_q, adr2_q;
    logic              vld1_q, vld2_q;
    logic [DATA_W-1:0] rd_data_s, exp_data_s;
    logic [ADDR_W-1:0] exp_addr_s;
    logic              rd_valid_s, mismatch;

    // Test pattern for a given mode and address (mode 01 shares mode 00 data).
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] base;
        base = DATA_W'(a);
        case (m)
            2'b10:   pattern = a[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
            2'b11:   pattern = ~base;
            default: pattern = base;
        endcase
    endfunction

`ifdef RAM_BIST_ERR_INJECT_EN
    assign inj_d = (state_q == S_IDLE && bus.start) ? bus.err_inject : inj_q;
    assign wdata = pattern(mode_q, waddr) ^ {{(DATA_W-1){1'b0}}, inj_q && (waddr == ADDR_W'(3))};
`else
    assign inj_d = 1'b0;
    assign wdata = pattern(mode_q, waddr);
`endif

    // RAM write port: WRITE pass only.
    always_ff @(posedge clk) begin
        if (wren) mem[waddr] <= wdata;
    end

    // Read pipeline: RAM data, expected data/address and valid travel together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q  <= '0; rd2_q  <= '0;
            exp1_q <= '0; exp2_q <= '0;
            adr1_q <= '0; adr2_q <= '0;
            vld1_q <= 1'b0; vld2_q <= 1'b0;
        end else begin
            rd1_q  <= rden ? mem[raddr] : rd1_q;
            rd2_q  <= rd1_q;
            exp1_q <= pattern(mode_q, raddr);
            exp2_q <= exp1_q;
            adr1_q <= raddr;
            adr2_q <= adr1_q;
            vld1_q <= rden;
            vld2_q <= vld1_q;
        end
    end

    assign rd_data_s  = (RD_LAT == 1) ? rd1_q  : rd2_q;
    assign exp_data_s = (RD_LAT == 1) ? exp1_q : exp2_q;
    assign exp_addr_s = (RD_LAT == 1) ? adr1_q : adr2_q;
    assign rd_valid_s = (RD_LAT == 1) ? vld1_q : vld2_q;
    assign mismatch   = rd_valid_s && (rd_data_s != exp_data_s);

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= 2'b00;
            err_cnt_q <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
            inj_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
            inj_q     <= inj_d;
        end
    end

    // Next-state, counters, RAM strobes and mismatch bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        pass_d    = pass_q;
        wren      = 1'b0;
        rden      = 1'b0;
        waddr     = cnt_q[ADDR_W-1:0];
        raddr     = (mode_q == 2'b01) ? ~cnt_q[ADDR_W-1:0] : cnt_q[ADDR_W-1:0];

        if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_d = exp_addr_s;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_WRITE;
                    cnt_d     = '0;
                    mode_d    = bus.mode;
                    err_cnt_d = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                end
            end
            S_WRITE: begin
                wren = 1'b1;
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = (GAP_CYC == 0) ? S_READ : S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                rden = 1'b1;
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // The final compare happens on the last drain cycle, so the
                // verdict uses the count including that compare.
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.first_err_addr = first_q;
    assign bus.rd_data        = rd_data_s;
    assign bus.rd_valid       = rd_valid_s;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl (DATA_W=8, ADDR_W=4,
// GAP_CYC=3, RD_LAT=1). Define RAM_BIST_ERR_INJECT_EN to add the injection test.
module tb_ram_bist_ctrl;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int GAP_CYC  = 3;
    localparam int RD_LAT   = 1;
    localparam int N        = 16;
    localparam int DONE_CYC = 2 * N + GAP_CYC + RD_LAT + 1;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_bist_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
    logic [2:0] dbg_state;

    ram_bist_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAP_CYC(GAP_CYC), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    // Scoreboard
    logic [DATA_W-1:0] exp_q[$];
    int n_chk    = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] m, input int a);
        case (m)
            2'd2:    model = (a % 2 == 1) ? 8'hAA : 8'h55;
            2'd3:    model = 8'(255 - a);
            default: model = 8'(a);
        endcase
    endfunction

    // Output monitor: every compared read word is popped and checked.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) done_cnt++;
            if (bus.rd_valid) begin
                rd_cnt++;
                if (exp_q.size() == 0) chk("rd_unexpected", 32'(bus.rd_valid), 32'd0);
                else chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver: one full test, optional second start pulse 5 cycles in.
    task automatic run_test(input logic [1:0] m, input logic inj, input logic restart);
        int cyc;
        int got;
        int a;
        logic [7:0] d;
        for (int i = 0; i < N; i++) begin
            a = (m == 2'd1) ? (N - 1 - i) : i;
            d = model(m, a);
            if (inj && a == 3) d = d ^ 8'h01;
            exp_q.push_back(d);
        end
        rd_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
`ifdef RAM_BIST_ERR_INJECT_EN
        bus.err_inject = inj;
`endif
        cyc = 0;
        got = -1;
        while (got < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start = restart && (cyc == 5);
            if (bus.done) got = cyc;
        end
        chk("done_cycle", 32'(got), 32'(DONE_CYC));
        chk("pass", 32'(bus.pass), 32'(!inj));
        chk("err_cnt", 32'(bus.err_cnt), inj ? 32'd1 : 32'd0);
        chk("first_err_addr", 32'(bus.first_err_addr), inj ? 32'd3 : 32'd0);
        chk("rd_valid_count", 32'(rd_cnt), 32'(N));
        chk("queue_left", 32'(exp_q.size()), 32'd0);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("done_width", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("pass_hold", 32'(bus.pass), 32'(!inj));
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pass", 32'(bus.pass), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("rst_first_err", 32'(bus.first_err_addr), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int done_before;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
`ifdef RAM_BIST_ERR_INJECT_EN
        bus.err_inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test(2'd0, 1'b0, 1'b0);
        run_test(2'd1, 1'b0, 1'b0);
        run_test(2'd2, 1'b0, 1'b0);
        run_test(2'd3, 1'b0, 1'b0);
        run_test(2'd0, 1'b0, 1'b1);

        // Abort mid-WRITE with reset, then confirm no done and a clean rerun.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        done_before = done_cnt;
        repeat (60) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(done_before));
        chk("abort_idle", 32'(bus.busy), 32'd0);
        run_test(2'd0, 1'b0, 1'b0);

`ifdef RAM_BIST_ERR_INJECT_EN
        run_test(2'd0, 1'b1, 1'b0);
        run_test(2'd0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
